midi_rx_fifo: RTL and testbench
===============================

MIDI_RX_FIFO -- requirements
Module: midi_rx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 31250, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (1600 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 16, receive buffer entries; power of two, minimum 2.
REQ-004 Parameter SYNC_STAGES, default 2, input synchronizer flops; minimum 2.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 midi_signal  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-008 byte_out  output  8  byte at the FIFO head.
REQ-009 byte_valid  output  1  high while the FIFO is non-empty.
REQ-010 byte_ready  input  1  consumer accept; a pop occurs on any cycle with byte_valid and byte_ready both high.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-012 framing_error  output  1  one-cycle pulse per frame with a low stop bit.
REQ-013 overflow  output  1  one-cycle pulse per byte dropped because the FIFO is full.

Function
REQ-014 midi_signal SHALL pass through SYNC_STAGES flops before any use; all sampling uses the synchronized value.
REQ-015 The receiver SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE with a bit counter of width $clog2(CLKS_PER_BIT).
REQ-016 IDLE: a synchronized high-to-low transition SHALL move to START and clear the bit counter.
REQ-017 START: after CLKS_PER_BIT/2 cycles the line SHALL be sampled; low -> DATA; high (glitch) -> IDLE with nothing pushed.
REQ-018 DATA: 8 samples SHALL be taken at CLKS_PER_BIT intervals and shifted in LSB first; after the 8th sample -> STOP.
REQ-019 STOP: the line SHALL be sampled after CLKS_PER_BIT cycles; high -> push byte, -> IDLE; low -> framing_error pulse, discard byte, -> WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL hold until the synchronized line is high, then -> IDLE; no falling edge is detected while in WAIT_IDLE.
REQ-021 The push SHALL occur on the clock edge at which the stop bit is sampled; byte_valid and fifo_count reflect it on the following cycle.
REQ-022 The FIFO SHALL be first-word-fall-through: byte_out = head entry whenever byte_valid is high, and 8'h00 when empty.
REQ-023 Read and write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-024 Push while full with no pop in the same cycle: byte dropped, contents unchanged, overflow pulses for one cycle.
REQ-025 Push and pop in the same cycle while full: both SHALL occur, no overflow, and fifo_count stays FIFO_DEPTH.
REQ-026 Push and pop in the same cycle while non-empty and non-full: both SHALL occur, and fifo_count is unchanged.
REQ-027 byte_ready while empty SHALL be ignored; pointers and fifo_count are unchanged.
REQ-028 framing_error and overflow SHALL never be high for two consecutive cycles from a single event.

Reset
REQ-029 With rst high on a clock edge: state IDLE, bit counter 0, shift register 0, pointers 0, fifo_count 0, byte_valid 0, byte_out 8'h00, framing_error 0, overflow 0; synchronizer flops set to 1 (idle).
REQ-030 Reset mid-frame SHALL abandon the frame with no push and no error pulse; FIFO memory contents need not be cleared.

Verification
REQ-031 Frame 0x90 at 31250 baud, byte_ready low -> byte_valid high one cycle after the stop sample, byte_out=0x90, fifo_count=1.
REQ-032 Frames 0x90,0x3C,0x7F back-to-back, then byte_ready held high -> byte_out sequence 0x90,0x3C,0x7F on consecutive cycles, then fifo_count=0.
REQ-033 Frame 0x55 with stop bit low -> one framing_error pulse, fifo_count unchanged; the next valid 0xAA is received correctly once the line returns high.
REQ-034 Low glitch of 100 cycles on an idle line -> no push, state returns to IDLE, no error pulse.
REQ-035 FIFO_DEPTH+1 frames (0x00..0x10) with byte_ready low -> fifo_count=16, one overflow pulse, and drain yields 0x00..0x0F.
REQ-036 rst asserted during the DATA bit 4 of frame 0xF8 -> all outputs at reset values, and no byte appears after rst is released with the line idle.

Source files
------------

// File: rtl/midi_rx_fifo_if.sv
// Consumer-side bus of the MIDI receiver: FWFT byte stream, occupancy and event pulses.
interface midi_rx_fifo_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       byte_out;
   logic             byte_valid;
   logic             byte_ready;
   logic [CNT_W-1:0] fifo_count;
   logic             framing_error;
   logic             overflow;

   modport master (
      output byte_out, byte_valid, fifo_count, framing_error, overflow,
      input  byte_ready
   );

   modport slave (
      input  byte_out, byte_valid, fifo_count, framing_error, overflow,
      output byte_ready
   );
endinterface

// File: rtl/midi_rx_fifo.sv
// MIDI (8N1) serial receiver feeding a first-word-fall-through byte FIFO.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | line idle, waiting for a synchronized falling edge
// ST_START   | half a bit in, confirming the start bit is still low
// ST_DATA    | sampling 8 data bits at bit-centre, LSB first
// ST_STOP    | sampling the stop bit; high pushes, low flags framing error
// ST_WAIT    | after a bad stop bit, waiting for the line to return high
module midi_rx_fifo #(
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD        = 31250,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             midi_signal,
   midi_rx_fifo_if.master   bus
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int NW   = PW + 1;
   localparam logic [CW-1:0] HALF_TC  = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] BIT_TC   = CW'(CPB - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx;
   logic                   rx_prev_q;

   logic [2:0]    state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          framing_error_q;
   logic          push;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [NW-1:0] count_q;
   logic          overflow_q;
   logic          full;
   logic          not_empty;
   logic          pop;
   logic          wr_en;

   assign rx = sync_q[SYNC_STAGES-1];

   // Synchronizer resets to idle-high so reset release never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], midi_signal};
         rx_prev_q <= rx;
      end
   end

   assign push = (state_q == ST_STOP) && (cnt_q == BIT_TC) && rx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         bit_q           <= '0;
         shift_q         <= '0;
         framing_error_q <= 1'b0;
      end else begin
         framing_error_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_prev_q && !rx) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
               end
            end
            ST_START: begin
               if (cnt_q == HALF_TC) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DATA: begin
               if (cnt_q == BIT_TC) begin
                  cnt_q   <= '0;
                  shift_q <= {rx, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_STOP: begin
               if (cnt_q == BIT_TC) begin
                  cnt_q <= '0;
                  if (rx) begin
                     state_q <= ST_IDLE;
                  end else begin
                     framing_error_q <= 1'b1;
                     state_q         <= ST_WAIT;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_WAIT: begin
               if (rx) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign full      = (count_q == FULL_CNT);
   assign not_empty = (count_q != '0);
   assign pop       = not_empty && bus.byte_ready;
   // A simultaneous pop frees the slot, so a push while full still lands.
   assign wr_en     = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= push && full && !pop;
         if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + NW'(1);
            2'b01:   count_q <= count_q - NW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.byte_valid    = not_empty;
   assign bus.byte_out      = not_empty ? mem[rd_ptr_q] : 8'h00;
   assign bus.fifo_count    = count_q;
   assign bus.framing_error = framing_error_q;
   assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_midi_rx_fifo.sv
// Bench for midi_rx_fifo: bit-level frame driver, queue-based FIFO model and pulse monitors.
module tb_midi_rx_fifo;
   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 31250;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic midi_signal = 1'b1;

   midi_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

   midi_rx_fifo #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .midi_signal(midi_signal), .bus(bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];
   int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
   bit rand_ready = 0;
   bit fe_prev = 0, ov_prev = 0;

   task automatic check(string tag, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) bus.byte_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic hold_line(logic v, int n);
      midi_signal = v;
      repeat (n) tick();
   endtask

   task automatic model_push(logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ov++;
   endtask

   task automatic send_frame(logic [7:0] b, bit stop_ok, int gap);
      hold_line(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
      if (stop_ok) model_push(b);
      else exp_fe++;
      hold_line(stop_ok, CPB);
      hold_line(1'b1, gap);
   endtask

   task automatic drain();
      bus.byte_ready = 1'b1;
      repeat (DEPTH + 4) tick();
      bus.byte_ready = 1'b0;
      check("drain_count", bus.fifo_count, 0);
   endtask

   // Scoreboard and pulse-width monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.byte_valid && bus.byte_ready) begin
            if (exp_q.size() == 0) check("pop_empty_model", bus.byte_valid, 0);
            else check("byte_out", bus.byte_out, exp_q.pop_front());
         end
         if (bus.framing_error) begin
            fe_cnt++;
            check("fe_width", fe_prev, 0);
         end
         if (bus.overflow) begin
            ov_cnt++;
            check("ov_width", ov_prev, 0);
         end
      end
      fe_prev = bus.framing_error;
      ov_prev = bus.overflow;
   end

   initial begin
      int first;
      logic [7:0] b;
      bus.byte_ready = 1'b0;
      repeat (3) tick();
      check("rst_valid", bus.byte_valid, 0);
      check("rst_count", bus.fifo_count, 0);
      check("rst_byte",  bus.byte_out, 0);
      check("rst_fe",    bus.framing_error, 0);
      check("rst_ov",    bus.overflow, 0);
      rst = 1'b0;
      hold_line(1'b1, CPB);

      // Single frame: valid must rise just after the stop-bit centre.
      b = 8'h90;
      hold_line(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
      model_push(b);
      check("t1_early_valid", bus.byte_valid, 0);
      midi_signal = 1'b1;
      first = -1;
      for (int k = 1; k <= CPB; k++) begin
         tick();
         if (bus.byte_valid && first < 0) first = k;
      end
      check("t1_latency_in_window", int'(first >= CPB / 2 && first <= CPB / 2 + 5), 1);
      check("t1_byte", bus.byte_out, 8'h90);
      check("t1_count", bus.fifo_count, 1);
      drain();

      // Back-to-back frames, then a continuous drain.
      send_frame(8'h90, 1, 0);
      send_frame(8'h3C, 1, 0);
      send_frame(8'h7F, 1, CPB);
      check("b2b_count", bus.fifo_count, 3);
      bus.byte_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("b2b_valid", bus.byte_valid, 1);
      end
      @(negedge clk);
      check("b2b_empty", bus.fifo_count, 0);
      repeat (4) tick();
      check("ready_when_empty", bus.fifo_count, 0);
      bus.byte_ready = 1'b0;

      // Bad stop bit then recovery.
      send_frame(8'h55, 0, CPB);
      check("fe_count", fe_cnt, exp_fe);
      check("fe_no_push", bus.fifo_count, 0);
      send_frame(8'hAA, 1, CPB);
      check("fe_recover_count", bus.fifo_count, 1);
      drain();

      // Short low glitch on an idle line.
      hold_line(1'b0, 10);
      hold_line(1'b1, 2 * CPB);
      check("glitch_count", bus.fifo_count, 0);
      check("glitch_fe", fe_cnt, exp_fe);
      send_frame(8'h42, 1, CPB);
      check("post_glitch_count", bus.fifo_count, 1);
      drain();

      // Overflow: one more frame than the FIFO holds.
      for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1, 0);
      hold_line(1'b1, CPB);
      check("ovf_count", bus.fifo_count, DEPTH);
      check("ovf_pulses", ov_cnt, exp_ov);
      drain();

      // Randomized frames with a randomly stalling consumer.
      rand_ready = 1;
      for (int n = 0; n < 12; n++) begin
         send_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 2 * CPB));
         check("rand_count", bus.fifo_count, exp_q.size());
      end
      rand_ready = 0;
      drain();
      check("rand_fe", fe_cnt, exp_fe);
      check("rand_ov", ov_cnt, exp_ov);

      // Reset in the middle of data bit 4 of 0xF8, with a byte already queued.
      send_frame(8'h11, 1, CPB);
      b = 8'hF8;
      hold_line(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold_line(b[i], CPB);
      hold_line(b[4], CPB / 2);
      rst = 1'b1;
      repeat (2) tick();
      exp_q.delete();
      check("mid_rst_valid", bus.byte_valid, 0);
      check("mid_rst_count", bus.fifo_count, 0);
      check("mid_rst_byte",  bus.byte_out, 0);
      check("mid_rst_fe",    bus.framing_error, 0);
      check("mid_rst_ov",    bus.overflow, 0);
      midi_signal = 1'b1;
      tick();
      rst = 1'b0;
      hold_line(1'b1, 12 * CPB);
      check("post_rst_count", bus.fifo_count, 0);
      check("post_rst_valid", bus.byte_valid, 0);
      check("post_rst_fe", fe_cnt, exp_fe);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
